// File: rtl/fir_ctrl_seq.sv
// fir_ctrl_seq - control sequencer for the multi-channel FIR datapath.
//
// Runs a programmable number of taps per output and a programmable number of
// samples per channel, time-multiplexing CHANNELS channels. Each output takes
// SHIFT + cfg_taps MAC cycles + STORE + OUT (cfg_taps+3 cycles with y_ready
// held high). One-shot runs end with a done pulse; continuous runs wrap the
// sample index and run until abort.
//
// Optional feature macro: FIR_CTRL_STALL_CNT_EN
//   defined     : stall_cnt counts OUT cycles with y_ready low (saturating)
//   not defined : stall_cnt tied to 0
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, abort       run control (start sampled in IDLE only, abort wins)
//   cfg_taps           tap count 1..TAPS_MAX (latched at start accept)
//   cfg_samples        samples per channel 1..SAMPLES_MAX (latched)
//   cfg_continuous     wrap sample index and run until abort (latched)
//   busy, mux_sel      state != IDLE
//   done, err_cfg      1-cycle pulses: normal completion / rejected start
//   shift_en, acc_clr, acc_en, acc_store   datapath strobes
//   tap_idx, ch_idx, sample_idx            datapath indices
//   y_valid, y_ready   output register handshake
//   stall_cnt          backpressure cycle count (see macro above)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, indices at 0
// INIT   | clear accumulator and indices, latch of cfg already done
// SHIFT  | push new sample of ch_idx into shift register, clear acc
// MAC    | accumulate tap tap_idx, cfg_taps cycles
// STORE  | latch accumulator into output register
// OUT    | y_valid high until y_ready, then advance channel/sample
// FINISH | done pulse

module fir_ctrl_seq #(
  parameter int TAPS_MAX    = 64,
  parameter int SAMPLES_MAX = 1024,
  parameter int CHANNELS    = 2,
  localparam int TAP_W      = $clog2(TAPS_MAX),
  localparam int SMP_W      = $clog2(SAMPLES_MAX),
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [TAP_W:0]   cfg_taps,
  input  logic [SMP_W:0]   cfg_samples,
  input  logic             cfg_continuous,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             mux_sel,
  output logic             shift_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             acc_store,
  output logic [TAP_W-1:0] tap_idx,
  output logic [CH_W-1:0]  ch_idx,
  output logic [SMP_W-1:0] sample_idx,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [15:0]      stall_cnt
);

  localparam logic [TAP_W:0]   TAPS_MAX_V = (TAP_W+1)'(TAPS_MAX);
  localparam logic [SMP_W:0]   SMP_MAX_V  = (SMP_W+1)'(SAMPLES_MAX);
  localparam logic [TAP_W:0]   TAP_ONE    = (TAP_W+1)'(1);
  localparam logic [SMP_W:0]   SMP_ONE    = (SMP_W+1)'(1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SHIFT,
    S_MAC,
    S_STORE,
    S_OUT,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic [TAP_W:0] taps_q;
  logic [SMP_W:0] samples_q;
  logic           cont_q;
  logic           err_q;

  logic cfg_ok;
  logic start_ok;
  logic kill;
  logic tap_last;
  logic ch_last;
  logic smp_last;
  logic hs;

  assign cfg_ok = (cfg_taps != '0) && (cfg_taps <= TAPS_MAX_V) &&
                  (cfg_samples != '0) && (cfg_samples <= SMP_MAX_V);
  assign start_ok = (state == S_IDLE) && start && cfg_ok;
  // abort has no effect in IDLE; everywhere else it overrides all other transitions
  assign kill     = abort && (state != S_IDLE);

  assign tap_last = ({1'b0, tap_idx} == (taps_q - TAP_ONE));
  assign ch_last  = (ch_idx == CH_LAST);
  assign smp_last = ({1'b0, sample_idx} == (samples_q - SMP_ONE));
  assign hs       = (state == S_OUT) && y_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    acc_store  = 1'b0;
    y_valid    = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_next = S_INIT;
      end
      S_INIT: begin
        acc_clr    = 1'b1;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en   = 1'b1;
        acc_clr    = 1'b1;
        state_next = S_MAC;
      end
      S_MAC: begin
        acc_en = 1'b1;
        if (tap_last) state_next = S_STORE;
      end
      S_STORE: begin
        acc_store  = 1'b1;
        state_next = S_OUT;
      end
      S_OUT: begin
        y_valid = 1'b1;
        if (y_ready) begin
          if (ch_last && smp_last && !cont_q) state_next = S_FINISH;
          else                                 state_next = S_SHIFT;
        end
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
  end

  assign busy    = (state != S_IDLE);
  assign mux_sel = busy;
  assign err_cfg = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == S_IDLE) && start && !cfg_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q     <= '0;
      samples_q  <= '0;
      cont_q     <= 1'b0;
      tap_idx    <= '0;
      ch_idx     <= '0;
      sample_idx <= '0;
    end else if (kill) begin
      tap_idx    <= '0;
      ch_idx     <= '0;
      sample_idx <= '0;
    end else begin
      if (start_ok) begin
        taps_q    <= cfg_taps;
        samples_q <= cfg_samples;
        cont_q    <= cfg_continuous;
      end
      if (state == S_INIT) begin
        tap_idx    <= '0;
        ch_idx     <= '0;
        sample_idx <= '0;
      end
      if (state == S_MAC) begin
        tap_idx <= tap_last ? '0 : tap_idx + TAP_W'(1);
      end
      if (hs) begin
        if (ch_last) begin
          ch_idx <= '0;
          // the final handshake of a one-shot run also wraps, leaving IDLE at 0
          sample_idx <= smp_last ? '0 : sample_idx + SMP_W'(1);
        end else begin
          ch_idx <= ch_idx + CH_W'(1);
        end
      end
    end
  end

`ifdef FIR_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == S_INIT) begin
      stall_q <= '0;
    end else if ((state == S_OUT) && !y_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fir_ctrl_seq.sv
// Directed testbench for fir_ctrl_seq (default parameters: 64 taps max,
// 1024 samples max, 2 channels). Honours FIR_CTRL_STALL_CNT_EN for the
// stall counter expectations.

module tb_fir_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  cfg_taps = '0;
  logic [10:0] cfg_samples = '0;
  logic        cfg_continuous = 1'b0;
  logic        busy, done, err_cfg, mux_sel;
  logic        shift_en, acc_clr, acc_en, acc_store;
  logic [5:0]  tap_idx;
  logic [0:0]  ch_idx;
  logic [9:0]  sample_idx;
  logic        y_valid;
  logic        y_ready = 1'b1;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state (written only by the monitor process)
  int mon_cyc  = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int strb_cnt = 0;
  int viol_cnt = 0;
  int hs_n     = 0;
  int hs_ch[256];
  int hs_smp[256];
  int hs_cyc[256];

  fir_ctrl_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_taps(cfg_taps), .cfg_samples(cfg_samples), .cfg_continuous(cfg_continuous),
    .busy(busy), .done(done), .err_cfg(err_cfg), .mux_sel(mux_sel),
    .shift_en(shift_en), .acc_clr(acc_clr), .acc_en(acc_en), .acc_store(acc_store),
    .tap_idx(tap_idx), .ch_idx(ch_idx), .sample_idx(sample_idx),
    .y_valid(y_valid), .y_ready(y_ready), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      mon_cyc <= mon_cyc + 1;
      if (acc_en) acc_cnt <= acc_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err_cfg) err_cnt <= err_cnt + 1;
      if (shift_en || acc_clr || acc_en || acc_store) strb_cnt <= strb_cnt + 1;
      if ((acc_en && (shift_en || acc_clr || acc_store)) ||
          (acc_store && (shift_en || acc_clr)) || (mux_sel !== busy))
        viol_cnt <= viol_cnt + 1;
      if (y_valid && y_ready && hs_n < 256) begin
        hs_ch[hs_n]  <= int'(ch_idx);
        hs_smp[hs_n] <= int'(sample_idx);
        hs_cyc[hs_n] <= mon_cyc;
        hs_n         <= hs_n + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int taps, input int smp, input logic cont);
    cfg_taps       = 7'(taps);
    cfg_samples    = 11'(smp);
    cfg_continuous = cont;
    start          = 1'b1;
    tick();
    start          = 1'b0;
  endtask

  // starts a one-shot run and measures it; optionally pulses start (with a
  // different config) while busy at tick busy_start_at
  task automatic run_cfg(input int taps, input int smp, input int busy_start_at,
                         output int t_done, output int mac_cyc, output int tap_max);
    t_done  = -1;
    mac_cyc = 0;
    tap_max = -1;
    do_start(taps, smp, 1'b0);
    for (int t = 1; t <= 3000; t++) begin
      if (t == busy_start_at) begin
        start       = 1'b1;
        cfg_taps    = 7'd1;
        cfg_samples = 11'd1;
      end
      tick();
      start = 1'b0;
      if (acc_en) begin
        mac_cyc++;
        if (int'(tap_idx) > tap_max) tap_max = int'(tap_idx);
      end
      if (done) begin
        t_done = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, err_cfg, mux_sel, shift_en, acc_clr, acc_en, acc_store, y_valid} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000000",
               {busy, done, err_cfg, mux_sel, shift_en, acc_clr, acc_en, acc_store, y_valid});
    end
    n_checks++;
    if ({tap_idx, ch_idx, sample_idx, stall_cnt} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_idx: tap=%0d ch=%0d smp=%0d stall=%0d want all 0",
               tap_idx, ch_idx, sample_idx, stall_cnt);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int b, a0, d0, t_done, mac, tmax;
    b  = hs_n;
    a0 = acc_cnt;
    d0 = done_cnt;
    run_cfg(4, 3, 0, t_done, mac, tmax);
    n_checks++;
    if (t_done !== 43) begin
      n_fail++;
      $display("FAIL basic_done_time: got %0d want 43", t_done);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_done: busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if (acc_cnt - a0 !== 24) begin
      n_fail++;
      $display("FAIL basic_acc_en: got %0d want 24", acc_cnt - a0);
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0);
    end
    n_checks++;
    if (hs_n - b !== 6) begin
      n_fail++;
      $display("FAIL basic_hs_count: got %0d want 6", hs_n - b);
    end
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (hs_ch[b+j] !== j % 2 || hs_smp[b+j] !== j / 2) begin
        n_fail++;
        $display("FAIL basic_order[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 j, hs_ch[b+j], hs_smp[b+j], j % 2, j / 2);
      end
    end
    for (int j = 1; j < 6; j++) begin
      n_checks++;
      if (hs_cyc[b+j] - hs_cyc[b+j-1] !== 7) begin
        n_fail++;
        $display("FAIL basic_period[%0d]: got %0d want 7", j, hs_cyc[b+j] - hs_cyc[b+j-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int b, t, t_done, bad, exp_stall;
`ifdef FIR_CTRL_STALL_CNT_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    b = hs_n;
    t_done = -1;
    bad = 0;
    do_start(4, 3, 1'b0);
    t = 0;
    while (t < 100) begin
      tick();
      t++;
      if (y_valid && (hs_n - b) == 1) break;
    end
    n_checks++;
    if (t !== 14) begin
      n_fail++;
      $display("FAIL bp_second_out: got t=%0d want 14", t);
    end
    y_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      t++;
      if (y_valid !== 1'b1 || ch_idx !== 1'b1 || sample_idx !== 10'd0 || acc_en !== 1'b0) bad++;
    end
    y_ready = 1'b1;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d cycles not holding, want 0", bad);
    end
    while (t < 300) begin
      tick();
      t++;
      if (done) begin
        t_done = t;
        break;
      end
    end
    n_checks++;
    if (t_done !== 48) begin
      n_fail++;
      $display("FAIL bp_done_time: got %0d want 48", t_done);
    end
    n_checks++;
    if (hs_n - b !== 6) begin
      n_fail++;
      $display("FAIL bp_hs_count: got %0d want 6", hs_n - b);
    end
    tick();
    n_checks++;
    if (int'(stall_cnt) !== exp_stall || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: got %0d busy=%b want %0d busy=0", stall_cnt, busy, exp_stall);
    end
  endtask

  task automatic test_invalid_cfg();
    int s0, e0;
    int bad_taps[4] = '{0, 4, 65, 4};
    int bad_smp[4]  = '{3, 0, 3, 1025};
    s0 = strb_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      do_start(bad_taps[k], bad_smp[k], 1'b0);
      n_checks++;
      if (err_cfg !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_err[%0d]: err_cfg=%b busy=%b want 1 0", k, err_cfg, busy);
      end
      tick();
      n_checks++;
      if (err_cfg !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_pulse[%0d]: err_cfg=%b busy=%b want 0 0", k, err_cfg, busy);
      end
    end
    n_checks++;
    if (strb_cnt - s0 !== 0 || err_cnt - e0 !== 4) begin
      n_fail++;
      $display("FAIL inv_summary: strobes=%0d errs=%0d want 0 4", strb_cnt - s0, err_cnt - e0);
    end
  endtask

  task automatic test_continuous();
    int b, d0, t, got_mac;
    b  = hs_n;
    d0 = done_cnt;
    do_start(2, 2, 1'b1);
    t = 0;
    while (t < 200 && (hs_n - b) < 6) begin
      tick();
      t++;
    end
    n_checks++;
    if (hs_n - b < 6) begin
      n_fail++;
      $display("FAIL cont_hs_timeout: got %0d handshakes want 6", hs_n - b);
    end
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (hs_ch[b+j] !== j % 2 || hs_smp[b+j] !== (j / 2) % 2) begin
        n_fail++;
        $display("FAIL cont_order[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 j, hs_ch[b+j], hs_smp[b+j], j % 2, (j / 2) % 2);
      end
    end
    n_checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_running: done_pulses=%0d busy=%b want 0 1", done_cnt - d0, busy);
    end
    got_mac = 0;
    for (int k = 0; k < 20; k++) begin
      if (acc_en) begin
        got_mac = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (got_mac !== 1) begin
      n_fail++;
      $display("FAIL cont_mac_timeout: got %0d want 1", got_mac);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, done, mux_sel, shift_en, acc_clr, acc_en, acc_store, y_valid} !== 8'd0 ||
        {tap_idx, ch_idx, sample_idx} !== 17'd0) begin
      n_fail++;
      $display("FAIL cont_abort: flags=%b tap=%0d ch=%0d smp=%0d want all 0",
               {busy, done, mux_sel, shift_en, acc_clr, acc_en, acc_store, y_valid},
               tap_idx, ch_idx, sample_idx);
    end
    tick();
    tick();
    n_checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_no_done: done_pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_boundary();
    int t_done, mac, tmax;
    run_cfg(1, 1, 0, t_done, mac, tmax);
    n_checks++;
    if (t_done !== 9 || mac !== 2 || tmax !== 0) begin
      n_fail++;
      $display("FAIL bnd_taps1: t=%0d mac=%0d tapmax=%0d want 9 2 0", t_done, mac, tmax);
    end
    tick();
    // start pulsed mid-run with a different config must change nothing
    run_cfg(64, 1, 20, t_done, mac, tmax);
    n_checks++;
    if (t_done !== 135 || mac !== 128 || tmax !== 63) begin
      n_fail++;
      $display("FAIL bnd_taps64: t=%0d mac=%0d tapmax=%0d want 135 128 63", t_done, mac, tmax);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_rst_mid_out();
    int got_out;
    do_start(4, 3, 1'b0);
    y_ready = 1'b0;
    got_out = 0;
    for (int k = 0; k < 30; k++) begin
      if (y_valid) begin
        got_out = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (got_out !== 1) begin
      n_fail++;
      $display("FAIL rst_out_timeout: got %0d want 1", got_out);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, err_cfg, mux_sel, shift_en, acc_clr, acc_en, acc_store, y_valid} !== 9'd0 ||
        {tap_idx, ch_idx, sample_idx} !== 17'd0) begin
      n_fail++;
      $display("FAIL rst_async: flags=%b tap=%0d ch=%0d smp=%0d want all 0",
               {busy, done, err_cfg, mux_sel, shift_en, acc_clr, acc_en, acc_store, y_valid},
               tap_idx, ch_idx, sample_idx);
    end
    tick();
    rst = 1'b0;
    y_ready = 1'b1;
    tick();
  endtask

  task automatic test_strobes();
    n_checks++;
    if (viol_cnt !== 0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: got %0d violating cycles want 0", viol_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_invalid_cfg();
    test_continuous();
    test_boundary();
    test_rst_mid_out();
    test_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_ctrl_seq.md
Name: fir_ctrl_seq

Overview:
Parametrised control sequencer for the multi-channel FIR datapath, replacing the fixed-schedule controller. It owns the tap and sample counters internally; they are no longer external full flags. Tap count and sample count are run-time programmable, channels are time-multiplexed, and the block supports a one-shot or continuous mode. It drives the CDC/input/output muxes, shift register, accumulator and coefficient address, and waits on a valid/ready handshake at the output.

Parameters:
TAPS_MAX, 64, maximum filter length; TAP_W = $clog2(TAPS_MAX)
SAMPLES_MAX, 1024, maximum samples per run; SMP_W = $clog2(SAMPLES_MAX)
CHANNELS, 2, interleaved channels; CH_W = max(1,$clog2(CHANNELS))

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin run (sampled in IDLE only)
abort  in  1  terminate run immediately
cfg_taps  in  TAP_W+1  tap count, valid range 1..TAPS_MAX
cfg_samples  in  SMP_W+1  samples per channel, valid range 1..SAMPLES_MAX
cfg_continuous  in  1  1 = wrap sample counter, run until abort
busy  out  1  state != IDLE
done  out  1  1-cycle pulse, run completed normally
err_cfg  out  1  1-cycle pulse, start rejected for invalid config
mux_sel  out  1  datapath muxes (CDC/in/out) owned by the sequencer; equals busy
shift_en  out  1  push new sample of channel ch_idx into the shift register
acc_clr  out  1  clear accumulator
acc_en  out  1  accumulate tap tap_idx
acc_store  out  1  latch accumulator into output register
tap_idx  out  TAP_W  current tap / coefficient address
ch_idx  out  CH_W  current channel
sample_idx  out  SMP_W  current sample index
y_valid  out  1  output register holds a result
y_ready  in  1  downstream accepts the result
stall_cnt  out  16  see Optional Feature

Behaviour:
- Reset: state IDLE. All outputs and counters are 0.
- Latched config: cfg_* is captured on the start-accept edge. Later changes are ignored until the next start.
- IDLE: if start and cfg valid -> INIT. If start and cfg invalid (taps = 0, taps > TAPS_MAX, samples = 0, samples > SAMPLES_MAX) -> err_cfg pulse and stay in IDLE.
- INIT (1 cycle): acc_clr = 1. Clear tap_idx, ch_idx and sample_idx. Clear stall_cnt. -> SHIFT.
- SHIFT (1 cycle): shift_en = 1, acc_clr = 1, tap_idx = 0. -> MAC.
- MAC (cfg_taps cycles): acc_en = 1; tap_idx counts 0..cfg_taps-1. -> STORE on the cycle where tap_idx = cfg_taps-1.
- STORE (1 cycle): acc_store = 1. -> OUT.
- OUT: y_valid = 1 and held until y_ready. On the handshake cycle, advance counters:
  - ch_idx increments.
  - At CHANNELS-1, ch_idx wraps to 0 and sample_idx increments.
  - If the channel wraps and sample_idx = cfg_samples-1: with cfg_continuous, sample_idx wraps to 0 and -> SHIFT; otherwise -> FINISH.
  - Else -> SHIFT.
- FINISH (1 cycle): done = 1. -> IDLE.
- Throughput: cfg_taps+3 cycles per output with y_ready held high.
- abort: highest priority in any state other than IDLE. Next state is IDLE, all strobes drop, and done is not pulsed. An in-flight y_valid is withdrawn.
- start while busy: ignored.
- cfg_taps = 1: MAC lasts one cycle, and STORE follows directly.
- CHANNELS = 1: ch_idx is constant 0.
- rst asserted mid-run: immediate return to IDLE, outputs 0.
- Strobes shift_en, acc_clr, acc_en and acc_store are mutually exclusive except shift_en+acc_clr in SHIFT.

Optional Feature:
Macro FIR_CTRL_STALL_CNT_EN.
- Defined: stall_cnt is a 16-bit counter that saturates at 16'hFFFF. It counts cycles in OUT with y_ready = 0. It is cleared in INIT and holds its value after done or abort.
- Not defined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Basic run: taps = 4, samples = 3, CHANNELS = 2, continuous = 0, y_ready = 1, start pulse -> exactly 6 handshakes with (ch, sample) order (0,0)(1,0)(0,1)(1,1)(0,2)(1,2); acc_en high 24 cycles total; 7 cycles per output; single done pulse 43 clocks after the start-sampling edge; busy then falls.
- Backpressure: same config, y_ready low for 5 cycles at the 2nd output -> y_valid held, counters frozen, done delayed by 5 cycles; with macro, stall_cnt = 5.
- Invalid config: start with taps = 0, then with samples = 0 -> err_cfg pulse each time, busy stays 0, no strobes.
- Continuous mode: taps = 2, samples = 2, continuous = 1 -> sample_idx wraps 1 -> 0 with no done; abort mid-MAC -> IDLE next cycle, no done, all outputs 0.
- Boundary: taps = 1 and taps = TAPS_MAX -> MAC length 1 / 64 cycles, tap_idx reaches 0 / 63; start pulsed while busy is ignored; rst asserted mid-OUT clears all outputs asynchronously.
